alu_stim_checker: RTL and testbench
===================================

ALU_STIM_CHECKER -- requirements
Module: alu_stim_checker

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, giving the clock edges to wait between driving ALU operands and sampling the ALU result (legal range 1..15).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the pass/fail counters.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port cmd_valid  input  1  command transaction present.
REQ-006 Port cmd_ready  output  1  block can accept a command.
REQ-007 Port cmd_in1 / cmd_in2  input  16 each  operands to apply.
REQ-008 Port cmd_ctrl  input  3  ALU opcode to apply.
REQ-009 Port cmd_exp  input  16  expected ALU result.
REQ-010 Port alu_in1 / alu_in2  output  16 each  registered operands driven to the external ALU.
REQ-011 Port alu_control  output  3  registered opcode driven to the external ALU.
REQ-012 Port alu_out  input  16  combinational result from the external ALU.
REQ-013 Port rsp_valid  output  1  check result available.
REQ-014 Port rsp_ready  input  1  consumer accepts result.
REQ-015 Port rsp_pass  output  1  1 = sampled result equalled cmd_exp.
REQ-016 Port rsp_got  output  16  sampled alu_out value.
REQ-017 Port pass_cnt / fail_cnt  output  CNT_W each  running totals of passed/failed checks.
REQ-018 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT, RESP; cmd_ready SHALL equal (state == IDLE).
REQ-020 In IDLE, on a rising edge with cmd_valid && cmd_ready: latch cmd_exp, load alu_in1/alu_in2/alu_control from cmd_*, load settle counter with SETTLE_CYCLES-1, go to WAIT.
REQ-021 In WAIT, the counter SHALL decrement each edge; on the edge where it equals 0, alu_out SHALL be sampled into rsp_got, rsp_pass SHALL be set to (alu_out == latched expected), FSM goes to RESP.
REQ-022 Latency: accept at edge T0 -> alu_out sampled at edge T0+SETTLE_CYCLES -> rsp_valid high in the cycle following that edge.
REQ-023 In RESP, rsp_valid SHALL be 1 and rsp_pass/rsp_got SHALL hold stable until rsp_valid && rsp_ready at an edge; FSM then returns to IDLE.
REQ-024 A new command SHALL NOT be accepted in the cycle the response is consumed; earliest next accept is the following edge (one transaction in flight, max throughput 1 per SETTLE_CYCLES+2 cycles).
REQ-025 alu_in1/alu_in2/alu_control SHALL hold the last driven values in all states until the next accept.
REQ-026 pass_cnt or fail_cnt SHALL increment by 1 at the sampling edge of REQ-021, never both.
REQ-027 Both counters SHALL saturate at all-ones (2^CNT_W-1) with no wrap.
REQ-028 Opcodes 101..111 SHALL be driven unmodified; comparison is against cmd_exp regardless of opcode.
REQ-029 cmd_* changes while not in IDLE SHALL have no effect.

Reset
REQ-030 Reset assertion SHALL asynchronously force state IDLE, alu_in1=0, alu_in2=0, alu_control=0, rsp_valid=0, rsp_pass=0, rsp_got=0, pass_cnt=0, fail_cnt=0, settle counter=0, busy=0.
REQ-031 Reset mid-transaction SHALL abandon it with no counter update and no response.
REQ-032 First accept after deassertion SHALL be possible at the first rising edge with rst_n high.

Structure
REQ-033 Package alu_pkg SHALL hold ALU_W=16, CTRL_W=3, opcode enum alu_op_e (ADD=000, SUB=001, AND=010, OR=011, XOR=100) and FSM state enum.
REQ-034 A sub-module sat_counter (parameter W; inputs clk, rst_n, inc; output count) SHALL be instantiated twice for pass_cnt and fail_cnt.

Verification (external 16-bit ALU model connected, SETTLE_CYCLES=1 unless stated)
REQ-035 Cmd 1234+5678 op 000 exp 68AC -> rsp_valid 2 cycles after accept, rsp_pass=1, rsp_got=68AC, pass_cnt=1.
REQ-036 Sequence SUB 9397,8356 exp 1041; AND FF00,0F0F exp 0F00; OR F0F0,0F0F exp FFFF; XOR FFFF,0000 exp FFFF -> all pass, pass_cnt=4, fail_cnt=0.
REQ-037 ADD 0001,0001 exp 0003 -> rsp_pass=0, rsp_got=0002, fail_cnt=1.
REQ-038 rsp_ready held low 5 cycles -> rsp_valid/rsp_got stable, cmd_ready=0, no second accept despite cmd_valid=1.
REQ-039 rst_n pulsed low during WAIT -> all outputs at reset values immediately, no counter change; CNT_W=2 with 5 passes -> pass_cnt=3.
REQ-040 SETTLE_CYCLES=4 -> alu_out sampled exactly 4 edges after accept (ALU model output delayed 3 cycles still passes).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared widths, ALU opcodes and checker FSM states for the ALU stimulus checker.
package alu_pkg;

  localparam int ALU_W  = 16;
  localparam int CTRL_W = 3;

  typedef enum logic [CTRL_W-1:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count increment requests, holding at the maximum value once reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/alu_stim_checker.sv
// Drives one command at a time into an external ALU, waits a fixed settle time,
// compares the ALU result against the expected value and reports pass/fail.
module alu_stim_checker
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ALU_W-1:0]  cmd_in1,
  input  logic [ALU_W-1:0]  cmd_in2,
  input  logic [CTRL_W-1:0] cmd_ctrl,
  input  logic [ALU_W-1:0]  cmd_exp,
  output logic [ALU_W-1:0]  alu_in1,
  output logic [ALU_W-1:0]  alu_in2,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [ALU_W-1:0]  alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_pass,
  output logic [ALU_W-1:0]  rsp_got,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              busy
);

  state_e           state;
  state_e           next_state;
  logic [3:0]       settle_cnt;
  logic [ALU_W-1:0] exp_q;
  logic             accept;
  logic             sample;
  logic             match;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign sample    = (state == WAIT) && (settle_cnt == 4'd0);
  assign match     = (alu_out == exp_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: accept, wait out the settle time, hold the response until taken.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cmd_valid)            next_state = WAIT;
      WAIT:    if (settle_cnt == 4'd0)   next_state = RESP;
      RESP:    if (rsp_ready)            next_state = IDLE;
      default:                           next_state = IDLE;
    endcase
  end

  // Operand/opcode launch, settle countdown and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_control <= '0;
      exp_q       <= '0;
      settle_cnt  <= '0;
      rsp_pass    <= 1'b0;
      rsp_got     <= '0;
    end else begin
      if (accept) begin
        alu_in1     <= cmd_in1;
        alu_in2     <= cmd_in2;
        alu_control <= cmd_ctrl;
        exp_q       <= cmd_exp;
        settle_cnt  <= 4'(SETTLE_CYCLES - 1);
      end else if (sample) begin
        rsp_got  <= alu_out;
        rsp_pass <= match;
      end else if (state == WAIT) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sample && match),
    .count (pass_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sample && !match),
    .count (fail_cnt)
  );

endmodule

// File: tb/tb_alu_stim_checker.sv
// Bench for alu_stim_checker: one instance with a combinational ALU (settle 1,
// 16-bit counters) and one with a 3-cycle-delayed ALU (settle 4, 2-bit counters).
module tb_alu_stim_checker;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Instance A signals
  logic        rst_n_a, cmd_valid_a, cmd_ready_a, rsp_valid_a, rsp_ready_a, rsp_pass_a, busy_a;
  logic [15:0] cmd_in1_a, cmd_in2_a, cmd_exp_a, alu_in1_a, alu_in2_a, alu_out_a, rsp_got_a;
  logic [2:0]  cmd_ctrl_a, alu_control_a;
  logic [15:0] pass_cnt_a, fail_cnt_a;

  // Instance B signals
  logic        rst_n_b, cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b, rsp_pass_b, busy_b;
  logic [15:0] cmd_in1_b, cmd_in2_b, cmd_exp_b, alu_in1_b, alu_in2_b, alu_out_b, rsp_got_b;
  logic [2:0]  cmd_ctrl_b, alu_control_b;
  logic [1:0]  pass_cnt_b, fail_cnt_b;
  logic [15:0] dly1, dly2, dly3;

  function automatic logic [15:0] alu_model(logic [15:0] a, logic [15:0] b, logic [2:0] op);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_out_a = alu_model(alu_in1_a, alu_in2_a, alu_control_a);

  // Slow ALU: result appears three edges after the operands change.
  always_ff @(posedge clk) begin
    dly1 <= alu_model(alu_in1_b, alu_in2_b, alu_control_b);
    dly2 <= dly1;
    dly3 <= dly2;
  end
  assign alu_out_b = dly3;

  alu_stim_checker #(.SETTLE_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_in1(cmd_in1_a), .cmd_in2(cmd_in2_a), .cmd_ctrl(cmd_ctrl_a), .cmd_exp(cmd_exp_a),
    .alu_in1(alu_in1_a), .alu_in2(alu_in2_a), .alu_control(alu_control_a), .alu_out(alu_out_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_pass(rsp_pass_a), .rsp_got(rsp_got_a),
    .pass_cnt(pass_cnt_a), .fail_cnt(fail_cnt_a), .busy(busy_a)
  );

  alu_stim_checker #(.SETTLE_CYCLES(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_in1(cmd_in1_b), .cmd_in2(cmd_in2_b), .cmd_ctrl(cmd_ctrl_b), .cmd_exp(cmd_exp_b),
    .alu_in1(alu_in1_b), .alu_in2(alu_in2_b), .alu_control(alu_control_b), .alu_out(alu_out_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_pass(rsp_pass_b), .rsp_got(rsp_got_b),
    .pass_cnt(pass_cnt_b), .fail_cnt(fail_cnt_b), .busy(busy_b)
  );

  typedef struct {
    logic [15:0] in1;
    logic [15:0] in2;
    logic [2:0]  ctrl;
    logic [15:0] exp;
    logic        pass;
    logic [15:0] got;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(string name, logic [31:0] got, logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Waits (bounded) for instance A to be ready, then presents one command for one edge.
  task automatic applyStimulus(logic [15:0] in1, logic [15:0] in2, logic [2:0] ctrl, logic [15:0] exp);
    int n = 0;
    while (!cmd_ready_a && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("a_cmd_ready_wait", cmd_ready_a, 1);
    cmd_in1_a = in1; cmd_in2_a = in2; cmd_ctrl_a = ctrl; cmd_exp_a = exp;
    cmd_valid_a = 1'b1;
    @(posedge clk); #1;
    cmd_valid_a = 1'b0;
  endtask

  task automatic applyStimulusB(logic [15:0] in1, logic [15:0] in2, logic [2:0] ctrl, logic [15:0] exp);
    int n = 0;
    while (!cmd_ready_b && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("b_cmd_ready_wait", cmd_ready_b, 1);
    cmd_in1_b = in1; cmd_in2_b = in2; cmd_ctrl_b = ctrl; cmd_exp_b = exp;
    cmd_valid_b = 1'b1;
    @(posedge clk); #1;
    cmd_valid_b = 1'b0;
  endtask

  task automatic consumeA();
    rsp_ready_a = 1'b1;
    @(posedge clk); #1;
    rsp_ready_a = 1'b0;
  endtask

  initial begin
    int exp_pass = 0;
    int exp_fail = 0;

    vecs[0] = '{16'h1234, 16'h5678, 3'b000, 16'h68AC, 1'b1, 16'h68AC};
    vecs[1] = '{16'h9397, 16'h8356, 3'b001, 16'h1041, 1'b1, 16'h1041};
    vecs[2] = '{16'hFF00, 16'h0F0F, 3'b010, 16'h0F00, 1'b1, 16'h0F00};
    vecs[3] = '{16'hF0F0, 16'h0F0F, 3'b011, 16'hFFFF, 1'b1, 16'hFFFF};
    vecs[4] = '{16'hFFFF, 16'h0000, 3'b100, 16'hFFFF, 1'b1, 16'hFFFF};
    vecs[5] = '{16'h0001, 16'h0001, 3'b000, 16'h0003, 1'b0, 16'h0002};
    vecs[6] = '{16'hABCD, 16'h1234, 3'b101, 16'h0000, 1'b1, 16'h0000};
    vecs[7] = '{16'h5555, 16'h3333, 3'b111, 16'h1111, 1'b0, 16'h0000};

    rst_n_a = 1'b0; cmd_valid_a = 1'b0; rsp_ready_a = 1'b0;
    cmd_in1_a = '0; cmd_in2_a = '0; cmd_ctrl_a = '0; cmd_exp_a = '0;
    rst_n_b = 1'b0; cmd_valid_b = 1'b0; rsp_ready_b = 1'b0;
    cmd_in1_b = '0; cmd_in2_b = '0; cmd_ctrl_b = '0; cmd_exp_b = '0;
    repeat (2) @(posedge clk);
    #1;

    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_cmd_ready", cmd_ready_a, 1);
    checkOutput("rst_rsp_valid", rsp_valid_a, 0);
    checkOutput("rst_alu_in1", alu_in1_a, 0);
    checkOutput("rst_pass_cnt", pass_cnt_a, 0);
    checkOutput("rst_fail_cnt", fail_cnt_a, 0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Table-driven vectors on instance A
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].in1, vecs[i].in2, vecs[i].ctrl, vecs[i].exp);
      checkOutput("vec_busy_after_accept", busy_a, 1);
      checkOutput("vec_rsp_valid_early", rsp_valid_a, 0);
      checkOutput("vec_alu_in1", alu_in1_a, vecs[i].in1);
      checkOutput("vec_alu_in2", alu_in2_a, vecs[i].in2);
      checkOutput("vec_alu_control", alu_control_a, vecs[i].ctrl);
      @(posedge clk); #1;
      checkOutput("vec_rsp_valid", rsp_valid_a, 1);
      checkOutput("vec_rsp_pass", rsp_pass_a, vecs[i].pass);
      checkOutput("vec_rsp_got", rsp_got_a, vecs[i].got);
      if (vecs[i].pass) exp_pass++; else exp_fail++;
      consumeA();
      checkOutput("vec_cmd_ready_after_consume", cmd_ready_a, 1);
      checkOutput("vec_pass_cnt", pass_cnt_a, exp_pass);
      checkOutput("vec_fail_cnt", fail_cnt_a, exp_fail);
    end

    // Back-pressure: response held, new commands ignored while busy
    applyStimulus(16'h0010, 16'h0020, 3'b000, 16'h0030);
    @(posedge clk); #1;
    cmd_in1_a = 16'h0100; cmd_in2_a = 16'h0200; cmd_ctrl_a = 3'b000; cmd_exp_a = 16'h0300;
    cmd_valid_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_rsp_valid", rsp_valid_a, 1);
      checkOutput("stall_rsp_got", rsp_got_a, 16'h0030);
      checkOutput("stall_cmd_ready", cmd_ready_a, 0);
      checkOutput("stall_alu_in1", alu_in1_a, 16'h0010);
      @(posedge clk); #1;
    end
    consumeA();
    checkOutput("consume_edge_no_accept", busy_a, 0);
    checkOutput("consume_pass_cnt", pass_cnt_a, exp_pass + 1);
    @(posedge clk); #1;
    cmd_valid_a = 1'b0;
    checkOutput("next_accept_busy", busy_a, 1);
    checkOutput("next_accept_alu_in1", alu_in1_a, 16'h0100);
    @(posedge clk); #1;
    checkOutput("next_rsp_got", rsp_got_a, 16'h0300);
    consumeA();
    checkOutput("next_pass_cnt", pass_cnt_a, exp_pass + 2);

    // Reset during WAIT abandons the transaction
    applyStimulus(16'h0005, 16'h0003, 3'b001, 16'h0002);
    checkOutput("pre_reset_busy", busy_a, 1);
    rst_n_a = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy_a, 0);
    checkOutput("mid_rst_rsp_valid", rsp_valid_a, 0);
    checkOutput("mid_rst_alu_in1", alu_in1_a, 0);
    checkOutput("mid_rst_alu_control", alu_control_a, 0);
    checkOutput("mid_rst_rsp_got", rsp_got_a, 0);
    checkOutput("mid_rst_pass_cnt", pass_cnt_a, 0);
    checkOutput("mid_rst_fail_cnt", fail_cnt_a, 0);
    @(posedge clk); #1;
    checkOutput("in_rst_no_response", rsp_valid_a, 0);
    cmd_in1_a = 16'h0007; cmd_in2_a = 16'h0001; cmd_ctrl_a = 3'b000; cmd_exp_a = 16'h0008;
    cmd_valid_a = 1'b1;
    #2;
    rst_n_a = 1'b1;
    @(posedge clk); #1;
    cmd_valid_a = 1'b0;
    checkOutput("post_rst_first_accept", busy_a, 1);
    checkOutput("post_rst_alu_in1", alu_in1_a, 16'h0007);
    @(posedge clk); #1;
    checkOutput("post_rst_rsp_pass", rsp_pass_a, 1);
    consumeA();
    checkOutput("post_rst_pass_cnt", pass_cnt_a, 1);
    checkOutput("post_rst_fail_cnt", fail_cnt_a, 0);

    // Instance B: settle 4 with delayed ALU, 2-bit counters saturate
    for (int t = 1; t <= 5; t++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'(t * 16'h0111);
      b = 16'(t * 16'h0023 + 1);
      applyStimulusB(a, b, 3'b000, a + b);
      for (int e = 0; e < 3; e++) begin
        @(posedge clk); #1;
        checkOutput("b_rsp_valid_before_settle", rsp_valid_b, 0);
      end
      @(posedge clk); #1;
      checkOutput("b_rsp_valid_at_settle", rsp_valid_b, 1);
      checkOutput("b_rsp_pass", rsp_pass_b, 1);
      checkOutput("b_rsp_got", rsp_got_b, a + b);
      rsp_ready_b = 1'b1;
      @(posedge clk); #1;
      rsp_ready_b = 1'b0;
    end
    checkOutput("b_pass_cnt_saturated", pass_cnt_b, 3);
    checkOutput("b_fail_cnt", fail_cnt_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
